ymf_write_queue: RTL
====================

// Module: ymf_write_queue
// PURPOSE
//  Downstream of the system glue-logic decode: takes CPU accesses to the YMF window (9F40/9F41)
//  and replays them to the YM sound chip with chip-legal strobe and recovery timing.
//  Writes are queued, so the CPU no longer needs a stretched bus cycle or busy polling.
//  Reads return a local status byte. Runs entirely on the fast board clock.
// PARAMETERS
//  DEPTH      4    queue entries; power of two, >=2
//  WR_PULSE   2    clk cycles ymWr_n held low, >=1
//  ADDR_WAIT  4    recovery clk cycles after an address-port (a0=0) write, >=1
//  DATA_WAIT  288  recovery clk cycles after a data-port (a0=1) write, >=1 (~18us at 16MHz)
// PORTS
//  clk        in   1  board clock (same clock that generates sysClk)
//  rst        in   1  asynchronous reset, active-low
//  cpuWr      in   1  one-clk pulse: qualified CPU write to YMF window
//  cpuRd      in   1  one-clk pulse: qualified CPU read of YMF window
//  cpuA0      in   1  adrBusLo[0] at the strobe; selects address (0) or data (1) port
//  cpuDat     in   8  CPU data, sampled on cpuWr
//  status     out  8  {busy, full, ovf, 2'b00, count[2:0]}; combinational from registers
//  ymCs_n     out  1  chip select to YM, active-low
//  ymWr_n     out  1  write strobe to YM, active-low
//  ymA0       out  1  YM port select
//  ymDat      out  8  data to YM
//  ymDatOe    out  1  high while ymDat must be driven onto the YM data pins
// BEHAVIOUR
//  Reset (async, rst=0): queue empty, ovf=0, state IDLE, ymCs_n=1, ymWr_n=1, ymA0=0,
//   ymDat=0, ymDatOe=0, wait counter=0. Reset mid-transfer aborts at once; the strobe rises async.
//  Queue entry = {a0, data[7:0]} (9 bits). count is 0..DEPTH; full = (count==DEPTH).
//  Push: cpuWr=1 and (!full or pop in same cycle) -> entry written at wr pointer, pointer wraps mod DEPTH.
//  cpuWr while full with no pop that cycle -> entry dropped, ovf<=1 (sticky).
//  cpuRd=1 -> ovf<=0 next edge; status value seen on that cycle still shows the old ovf.
//  cpuWr and cpuRd in the same cycle: both actions take effect.
//  busy = (count!=0) | (state!=IDLE).
//  FSM (all outputs registered):
//   IDLE  : if count!=0: pop head into ymA0/ymDat, ymCs_n<=0, ymDatOe<=1 -> SETUP. Else stay.
//   SETUP : 1 cycle (address/data setup before strobe); ymWr_n<=0 -> STROBE.
//   STROBE: stay WR_PULSE cycles with ymWr_n=0; then ymWr_n<=1 -> HOLD.
//   HOLD  : 1 cycle with cs and data held; then ymCs_n<=1, ymDatOe<=0,
//           load counter with (ymA0 ? DATA_WAIT : ADDR_WAIT)-1 -> WAIT.
//   WAIT  : decrement the counter; at 0 -> IDLE.
//  Back-to-back entries: gap from one ymWr_n rise to the next ymWr_n fall is exactly
//   1 (HOLD) + wait + 1 (IDLE) + 1 (SETUP) cycles. Each pop happens only on the IDLE->SETUP edge.
//  Push and pop in the same cycle with count==DEPTH: the push is accepted and count stays DEPTH.
//  Push into an empty queue cannot be popped in the same cycle; earliest pop is the next edge.
//  Counter width = $clog2(max(ADDR_WAIT,DATA_WAIT,WR_PULSE))+1; no wrap possible.
//  ymDat/ymA0 hold their last value outside transfers; only ymDatOe gates the pins.
// STRUCTURE
//  Package ymf_pkg: state enum {IDLE,SETUP,STROBE,HOLD,WAIT}; ENTRY_W=9; status bit indices.
//  Sub-module ymf_fifo: synchronous DEPTH x ENTRY_W FIFO with push/pop/count/full/empty
//   and async active-low reset. The FSM, timers, ovf flag and output registers live in the top.
// TESTING
//  1) Reset release, idle 20 clk -> ymCs_n=ymWr_n=1, ymDatOe=0, status=8'h00.
//  2) cpuWr a0=0 dat=8'h28 -> ymCs_n falls 1 clk later, ymWr_n low 2 clk with ymA0=0,
//     ymDat=8'h28; status bit7 stays 1 until 4 wait cycles have elapsed.
//  3) Writes a0=0/8'h20 then a0=1/8'hC7 back-to-back -> two strobes, second strobe fall
//     exactly 7 clk after first strobe rise; busy persists 288 clk after second.
//  4) Five writes while FSM stalled in DATA_WAIT (DEPTH=4) -> fifth dropped, status=8'hE4;
//     cpuRd -> next status=8'hC4; exactly 4 further strobes with original data order.
//  5) Queue full with IDLE->SETUP pop coinciding with cpuWr -> write accepted, ovf stays 0, count stays 4.
//  6) Assert rst while in STROBE -> ymWr_n, ymCs_n high and ymDatOe low async, count=0,
//     no strobe after release until a new cpuWr.

Source files
------------

// File: rtl/ymf_pkg.sv
// Shared types and constants for the YM write queue: FSM states, entry width
// and status-byte bit positions.
package ymf_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      WAIT   = 3'd4
   } ymf_state_e;

   localparam int ENTRY_W   = 9;
   localparam int STAT_BUSY = 7;
   localparam int STAT_FULL = 6;
   localparam int STAT_OVF  = 5;
   localparam int STAT_CNT  = 0;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ymf_write_queue_if.sv
// CPU-side strobe/status and YM-side pin signals of the write queue.
interface ymf_write_queue_if;
   logic       cpu_wr;
   logic       cpu_rd;
   logic       cpu_a0;
   logic [7:0] cpu_dat;
   logic [7:0] status;
   logic       ym_cs_n;
   logic       ym_wr_n;
   logic       ym_a0;
   logic [7:0] ym_dat;
   logic       ym_dat_oe;

   modport slave (
      input  cpu_wr, cpu_rd, cpu_a0, cpu_dat,
      output status, ym_cs_n, ym_wr_n, ym_a0, ym_dat, ym_dat_oe
   );

   modport master (
      output cpu_wr, cpu_rd, cpu_a0, cpu_dat,
      input  status, ym_cs_n, ym_wr_n, ym_a0, ym_dat, ym_dat_oe
   );
endinterface

// File: rtl/ymf_fifo.sv
// Synchronous FIFO; a push is accepted when full only if a pop happens the same cycle.
module ymf_fifo
   import ymf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = ENTRY_W,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     dout,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == CNT_W'(DEPTH));
   assign empty     = (count_r == {CNT_W{1'b0}});
   assign push_ok_s = push & (~full | pop_ok_s);
   assign pop_ok_s  = pop & ~empty;
   assign dout      = mem_r[rd_ptr_r];
   assign count     = count_r;

   // storage and pointers; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {W{1'b0}};
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
      end
   end

   // occupancy counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {CNT_W{1'b0}};
      end else begin
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/ymf_write_queue.sv
// Queues CPU writes to the YM window and replays them with chip-legal strobe
// and recovery timing; reads clear the sticky overflow flag.
module ymf_write_queue
   import ymf_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int WR_PULSE  = 2,
   parameter int ADDR_WAIT = 4,
   parameter int DATA_WAIT = 288
) (
   input  logic              clk,
   input  logic              rst_n,
   ymf_write_queue_if.slave  bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int TMR_W = $clog2(max3(ADDR_WAIT, DATA_WAIT, WR_PULSE)) + 1;

   ymf_state_e         state_r;
   logic [TMR_W-1:0]   tmr_r;
   logic               ovf_r;
   logic               ym_cs_n_r;
   logic               ym_wr_n_r;
   logic               ym_a0_r;
   logic [7:0]         ym_dat_r;
   logic               ym_dat_oe_r;

   logic [ENTRY_W-1:0] head_s;
   logic [CNT_W-1:0]   count_s;
   logic               full_s;
   logic               empty_s;
   logic               pop_s;
   logic               drop_s;
   logic [7:0]         status_s;

   assign pop_s  = (state_r == IDLE) & ~empty_s;
   assign drop_s = bus.cpu_wr & full_s & ~pop_s;

   ymf_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (bus.cpu_wr),
      .pop   (pop_s),
      .din   ({bus.cpu_a0, bus.cpu_dat}),
      .dout  (head_s),
      .count (count_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // sticky overflow: a dropped write sets it, a status read clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (drop_s) begin
         ovf_r <= 1'b1;
      end else if (bus.cpu_rd) begin
         ovf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   // transfer sequencer; every YM pin is driven straight from these registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         tmr_r       <= {TMR_W{1'b0}};
         ym_cs_n_r   <= 1'b1;
         ym_wr_n_r   <= 1'b1;
         ym_a0_r     <= 1'b0;
         ym_dat_r    <= 8'h00;
         ym_dat_oe_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (!empty_s) begin
                  ym_a0_r     <= head_s[8];
                  ym_dat_r    <= head_s[7:0];
                  ym_cs_n_r   <= 1'b0;
                  ym_dat_oe_r <= 1'b1;
                  state_r     <= SETUP;
               end else begin
                  state_r <= IDLE;
               end
            end
            SETUP: begin
               ym_wr_n_r <= 1'b0;
               tmr_r     <= TMR_W'(WR_PULSE - 1);
               state_r   <= STROBE;
            end
            STROBE: begin
               if (tmr_r == {TMR_W{1'b0}}) begin
                  ym_wr_n_r <= 1'b1;
                  state_r   <= HOLD;
               end else begin
                  tmr_r <= tmr_r - TMR_W'(1);
               end
            end
            HOLD: begin
               ym_cs_n_r   <= 1'b1;
               ym_dat_oe_r <= 1'b0;
               // data-port writes need the long recovery
               tmr_r       <= ym_a0_r ? TMR_W'(DATA_WAIT - 1) : TMR_W'(ADDR_WAIT - 1);
               state_r     <= WAIT;
            end
            WAIT: begin
               if (tmr_r == {TMR_W{1'b0}}) begin
                  state_r <= IDLE;
               end else begin
                  tmr_r <= tmr_r - TMR_W'(1);
               end
            end
            default: begin
               state_r     <= IDLE;
               ym_cs_n_r   <= 1'b1;
               ym_wr_n_r   <= 1'b1;
               ym_dat_oe_r <= 1'b0;
            end
         endcase
      end
   end

   // status byte assembled from registered state only
   always_comb begin
      status_s                      = 8'h00;
      status_s[STAT_BUSY]           = ~empty_s | (state_r != IDLE);
      status_s[STAT_FULL]           = full_s;
      status_s[STAT_OVF]            = ovf_r;
      status_s[STAT_CNT+2:STAT_CNT] = 3'(count_s);
   end

   assign bus.status    = status_s;
   assign bus.ym_cs_n   = ym_cs_n_r;
   assign bus.ym_wr_n   = ym_wr_n_r;
   assign bus.ym_a0     = ym_a0_r;
   assign bus.ym_dat    = ym_dat_r;
   assign bus.ym_dat_oe = ym_dat_oe_r;

endmodule
